// File: rtl/riscv_pkg.sv
// Shared types and constants for the riscv core front end.
package riscv_pkg;

    localparam int XLEN          = 32;
    localparam int FETCH_Q_DEPTH = 2;
    localparam int FETCH_Q_CW    = $clog2(FETCH_Q_DEPTH + 1);
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched instructions with synchronous flush; head reads 0 when empty.
module fetch_queue
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  fetch_entry_t          din,
    output fetch_entry_t          head,
    output logic [FETCH_Q_CW-1:0] count
);

    localparam int PW = $clog2(FETCH_Q_DEPTH);

    fetch_entry_t   entries [FETCH_Q_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FETCH_Q_DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= din;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + FETCH_Q_CW'(push) - FETCH_Q_CW'(pop);
        end
    end

    assign head = (count != '0) ? entries[rd_ptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, imem issue, redirect/kill, fault halt, decode queue.
// Optional FETCH_PERF_EN builds the fetched/flushed performance counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int          IMEM_DEPTH = 60,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fetch_err,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
);

    localparam int RW = FETCH_Q_CW + 1;
    localparam logic [XLEN:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;

    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       inflight_pc;
    logic                  inflight;
    logic                  err;
    logic [FETCH_Q_CW-1:0] q_count;
    logic [RW-1:0]         occ;
    fetch_entry_t          head;
    fetch_entry_t          din;
    logic                  pop;
    logic                  push;
    logic                  can_issue;
    logic                  in_range;
    logic                  issue;

    assign out_valid = (q_count != '0);
    assign pop       = out_valid && out_ready;
    assign occ       = RW'(q_count) + RW'(inflight) - RW'(pop);
    assign can_issue = !rst && !err && !redirect_valid && (occ < RW'(FETCH_Q_DEPTH));
    assign in_range  = ({1'b0, pc} < PC_LIMIT);
    assign issue     = can_issue && in_range;

    // A redirect in the response cycle kills the returning word.
    assign push      = inflight && !redirect_valid;
    assign din       = '{inst: imem_rdata, pc: inflight_pc};

    assign imem_en   = issue;
    assign imem_addr = pc;
    assign fetch_err = err;
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            err         <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (redirect_valid) pc <= {redirect_pc[31:2], 2'b00};
            if ((redirect_valid && redirect_pc[1:0] != 2'b00) || (can_issue && !in_range))
                err <= 1'b1;
        end
    end

    fetch_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .head  (head),
        .count (q_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_cnt;
    logic [31:0] flushed_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_cnt <= '0;
            flushed_cnt <= '0;
        end else begin
            fetched_cnt <= fetched_cnt + 32'(pop);
            // Entries accepted by decode in the redirect cycle are not flushed.
            if (redirect_valid)
                flushed_cnt <= flushed_cnt + 32'(q_count) + 32'(inflight) - 32'(pop);
        end
    end

    assign perf_fetched = fetched_cnt;
    assign perf_flushed = flushed_cnt;
`else
    assign perf_fetched = '0;
    assign perf_flushed = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: straight run, back-pressure, redirect, faults, async reset.
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_en, a_valid, a_err, a_ready, redir;
    logic [31:0] a_addr, a_inst, a_pc, a_fetched, a_flushed, redir_pc;
    logic [31:0] a_rdata = '0;

    logic        b_en, b_valid, b_err;
    logic        b_ready = 1'b1;
    logic        b_redir = 1'b0;
    logic [31:0] b_redir_pc = '0;
    logic [31:0] b_addr, b_inst, b_pc, b_fetched, b_flushed;
    logic [31:0] b_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // 1-cycle synchronous instruction memories
    always @(posedge clk) begin
        if (a_en) a_rdata <= word_at(a_addr);
        if (b_en) b_rdata <= word_at(b_addr);
    end

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .imem_en(a_en), .imem_addr(a_addr), .imem_rdata(a_rdata),
        .redirect_valid(redir), .redirect_pc(redir_pc), .out_valid(a_valid),
        .out_ready(a_ready), .out_inst(a_inst), .out_pc(a_pc), .fetch_err(a_err),
        .perf_fetched(a_fetched), .perf_flushed(a_flushed)
    );

    fetch_stage #(.IMEM_DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .imem_en(b_en), .imem_addr(b_addr), .imem_rdata(b_rdata),
        .redirect_valid(b_redir), .redirect_pc(b_redir_pc), .out_valid(b_valid),
        .out_ready(b_ready), .out_inst(b_inst), .out_pc(b_pc), .fetch_err(b_err),
        .perf_fetched(b_fetched), .perf_flushed(b_flushed)
    );

    // Leaves the bench at a negedge with cycle 0 pending.
    task automatic do_reset();
        rst = 1'b1; redir = 1'b0; redir_pc = '0; a_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_vld"}, 32'(a_valid), 32'd0);
        chk({tag, "_rst_err"}, 32'(a_err), 32'd0);
        chk({tag, "_rst_en"}, 32'(a_en), 32'd0);
        chk({tag, "_rst_fetched"}, a_fetched, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "_restart_en"}, 32'(a_en), 32'd1);
        chk({tag, "_restart_addr"}, a_addr, 32'd0);
    endtask

    initial begin
        redir = 1'b0; redir_pc = '0; a_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_en", 32'(a_en), 32'd0);
        chk("rst_addr", a_addr, 32'd0);
        chk("rst_vld", 32'(a_valid), 32'd0);
        chk("rst_inst", a_inst, 32'd0);
        chk("rst_pc", a_pc, 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_fetched", a_fetched, 32'd0);
        chk("rst_flushed", a_flushed, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // straight-line run; u_dut4 hits the end of its 4-word memory
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 0) begin
                chk("t1_en0", 32'(a_en), 32'd1);
                chk("t1_addr0", a_addr, 32'd0);
            end
            if (c >= 2 && c <= 5) begin
                chk("t1_vld", 32'(a_valid), 32'd1);
                chk("t1_pc", a_pc, 32'((c - 2) * 4));
                chk("t1_inst", a_inst, word_at(32'((c - 2) * 4)));
                chk("oor_pc", b_pc, 32'((c - 2) * 4));
            end
            if (c == 6) chk("t1_fetched", a_fetched, PERF ? 32'd4 : 32'd0);
            if (c == 3) chk("oor_addr12", b_en ? b_addr : 32'hFFFF_FFFF, 32'd12);
            if (c >= 4) chk("oor_no_issue", 32'(b_en), 32'd0);
            if (c == 4) chk("oor_err_pre", 32'(b_err), 32'd0);
            if (c == 5) chk("oor_err", 32'(b_err), 32'd1);
            if (c == 7) chk("oor_drained", 32'(b_valid), 32'd0);
            @(negedge clk);
        end

        // back-pressure, released in cycle 10
        do_reset();
        a_ready = 1'b0;
        for (int c = 0; c < 13; c++) begin
            if (c >= 10) a_ready = 1'b1;
            #1;
            if (c == 1) chk("bp_addr4", a_en ? a_addr : 32'hFFFF_FFFF, 32'd4);
            if (c >= 2 && c <= 9) begin
                chk("bp_stall_en", 32'(a_en), 32'd0);
                chk("bp_hold_pc", a_valid ? a_pc : 32'hFFFF_FFFF, 32'd0);
            end
            if (c == 10) chk("bp_addr8", a_en ? a_addr : 32'hFFFF_FFFF, 32'd8);
            if (c >= 10) chk("bp_order", a_valid ? a_pc : 32'hFFFF_FFFF, 32'((c - 10) * 4));
            @(negedge clk);
        end

        // redirect to 0x20 in cycle 4 with one queued and one in flight
        do_reset();
        for (int c = 0; c < 9; c++) begin
            a_ready  = (c != 4);
            redir    = (c == 4);
            redir_pc = 32'h20;
            #1;
            if (c == 3) chk("rd_pc4", a_valid ? a_pc : 32'hFFFF_FFFF, 32'd4);
            if (c == 4) begin
                chk("rd_head8", a_valid ? a_pc : 32'hFFFF_FFFF, 32'd8);
                chk("rd_no_issue", 32'(a_en), 32'd0);
            end
            if (c == 5) begin
                chk("rd_addr", a_en ? a_addr : 32'hFFFF_FFFF, 32'h20);
                chk("rd_flushed", a_flushed, PERF ? 32'd2 : 32'd0);
            end
            if (c == 5 || c == 6) chk("rd_bubble", 32'(a_valid), 32'd0);
            if (c == 7) begin
                chk("rd_first_pc", a_valid ? a_pc : 32'hFFFF_FFFF, 32'h20);
                chk("rd_first_inst", a_inst, word_at(32'h20));
            end
            if (c == 8) begin
                chk("rd_next_pc", a_pc, 32'h24);
                chk("rd_fetched", a_fetched, PERF ? 32'd3 : 32'd0);
            end
            @(negedge clk);
        end
        redir = 1'b0;

        // misaligned redirect with two entries queued
        do_reset();
        a_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            redir    = (c == 3);
            redir_pc = 32'h22;
            #1;
            if (c == 3) chk("mis_pre_vld", 32'(a_valid), 32'd1);
            if (c >= 4) begin
                chk("mis_err", 32'(a_err), 32'd1);
                chk("mis_no_issue", 32'(a_en), 32'd0);
                chk("mis_flushed_q", 32'(a_valid), 32'd0);
            end
            if (c == 4) chk("mis_flushed", a_flushed, PERF ? 32'd3 - 32'd1 : 32'd0);
            @(negedge clk);
        end
        redir = 1'b0;
        pulse_rst("mis");

        // async reset during a live straight run
        do_reset();
        for (int c = 0; c < 7; c++) begin
            #1;
            if (c == 6) chk("ar_live", a_valid ? a_pc : 32'hFFFF_FFFF, 32'd16);
            @(negedge clk);
        end
        pulse_rst("ar");
        @(negedge clk);
        #1;
        chk("ar_stale_drop", 32'(a_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("ar_first_pc", a_valid ? a_pc : 32'hFFFF_FFFF, 32'd0);
        chk("ar_first_inst", a_inst, word_at(32'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch front end of the `riscv` core. Owns the program counter, issues word reads to the instruction memory (synchronous, 1-cycle read latency), and buffers returned instructions in a 2-entry queue. It presents them to decode with a valid/ready handshake. It accepts PC redirects from execute (branch/jump), discards in-flight and queued instructions on a redirect, and halts on out-of-range or misaligned fetch addresses.

## Interface
Parameters:
- `IMEM_DEPTH`, 60: instruction memory size in 32-bit words; valid byte addresses are 0 to IMEM_DEPTH*4-4.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_en` out 1: read request this cycle.
- `imem_addr` out 32: byte address of the request; always word aligned.
- `imem_rdata` in 32: instruction word, valid the cycle after the `imem_en` cycle.
- `redirect_valid` in 1: execute requests a PC change.
- `redirect_pc` in 32: new fetch address.
- `out_valid` out 1: queue head valid.
- `out_ready` in 1: decode accepts the head.
- `out_inst` out 32: instruction at the queue head.
- `out_pc` out 32: byte address of `out_inst`.
- `fetch_err` out 1: sticky fault flag; fetching is halted while it is set.
- `perf_fetched` out 32: count of instructions handed to decode.
- `perf_flushed` out 32: count of instructions discarded by redirects.

## Operation
- Reset values: PC=RESET_PC, queue empty, no request in flight. Outputs: `imem_en`=0, `imem_addr`=RESET_PC, `out_valid`=0, `out_inst`=0, `out_pc`=0, `fetch_err`=0, both perf counters 0.
- Handshake: an entry transfers on `out_valid && out_ready` and is then popped. `out_inst` and `out_pc` hold stable while `out_valid` is set and `out_ready` is low.
- Issue rule: `imem_en` = !fetch_err && !redirect_valid && (count + inflight - pop) < 2. On issue, record the PC for the in-flight entry and advance PC by 4.
- Response: the cycle after an issue, push `imem_rdata` and its PC into the queue, unless the response is killed.
- Redirect has priority over every other event in its cycle:
  - Clear the queue.
  - Mark any in-flight request as killed.
  - Load PC with `redirect_pc`.
  - Issue no request that cycle.
  - A decode handshake in the same cycle still counts as a transfer.
  - `perf_flushed` += remaining queued entries + in-flight entries.
- Fault conditions:
  - A redirect with `redirect_pc[1:0]`≠0 sets `fetch_err`.
  - A PC ≥ IMEM_DEPTH*4 at issue time sets `fetch_err` instead of issuing.
  - On a fault the queue drains normally and no further requests are issued.
  - `fetch_err` is cleared only by `rst`.
- PC arithmetic is 32-bit unsigned and wraps mod 2^32; wrap-around necessarily raises the out-of-range fault.
- Mid-operation reset returns immediately to the reset values above; a response arriving after reset is ignored.

## Timing
- Cycle 0 is the first rising edge with `rst` low: `imem_en`=1, `imem_addr`=RESET_PC.
- Cycle 1: data is pushed into the queue.
- Cycle 2: `out_valid`=1 for RESET_PC. Request-to-decode latency is 2 cycles; there is no bypass path.
- Throughput is 1 instruction/cycle sustained when `out_ready` is held high.
- Redirect asserted in cycle N:
  - `imem_addr`=`redirect_pc` with `imem_en`=1 in cycle N+1.
  - First redirected instruction has `out_valid`=1 in cycle N+3.
  - `out_valid`=0 in cycles N+1 and N+2.
- Back-pressure: with `out_ready` low, at most 2 instructions are held and issue stops once count + inflight reaches 2.

## Configuration
- `FETCH_PERF_EN` defined: `perf_fetched` and `perf_flushed` are live, 32-bit, wrapping counters, reset to 0.
- `FETCH_PERF_EN` undefined: no counter logic is generated, and both ports are tied to 0.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`=32.
  - `FETCH_Q_DEPTH`=2.
  - `INST_NOP`=32'h0000_0013.
  - Typedef `fetch_entry_t` {inst, pc}.
- Sub-module `fetch_queue`: 2-entry FIFO of `fetch_entry_t` with push, pop, synchronous flush, `count`, and head output.
- PC, issue logic, kill tracking and error logic live in `fetch_stage`.

## Test plan
- Straight-line run: imem holds 4 instructions, `out_ready`=1 → PCs 0, 4, 8, 12 appear in cycles 2–5 with matching words; `perf_fetched`=4 after cycle 5.
- Back-pressure: `out_ready`=0 from cycle 0 → `imem_en` drops after 2 issues and `out_valid` holds PC 0. Raising `out_ready` in cycle 10 → PCs 0, 4, 8 delivered in order with no loss or duplication.
- Redirect: `redirect_valid` with pc=0x20 in cycle 4 (queue holding 1 entry, 1 in flight) → `imem_addr`=0x20 in cycle 5, first `out_pc`=0x20 in cycle 7, no stale PC emitted, `perf_flushed`=2.
- Misaligned redirect: pc=0x22 → `fetch_err`=1 next cycle, `imem_en` stays 0, and queued entries before the redirect are flushed.
- Out of range: IMEM_DEPTH=4 with a straight run → PCs 0–12 delivered, then `fetch_err`=1 with no request to 0x10.
- Async reset mid-run: `rst` pulsed for 3 ns in cycle 6 → `out_valid`=0 and `fetch_err`=0 immediately, and fetching restarts at RESET_PC.
